md5_block_padder: RTL and testbench
===================================

// Module: md5_block_padder
// PURPOSE
//  Downstream stage of the guess generator. Accepts one left-aligned,
//  null-terminated guess per handshake and emits a single MD5 512-bit message
//  block: message bytes, 0x80 pad, zero fill, bit length. The output feeds
//  the MD5 round pipeline. A registered skid stage decouples backpressure.
// PARAMETERS
//  MAX_CHARS  16  guess bytes carried on in_guess (8*MAX_CHARS bits, <=55)
//  CNT_W      48  width of the emitted-block counter (PADDER_COUNT_EN only)
// PORTS
//  clk        in   1    clock
//  reset      in   1    synchronous, active-high reset
//  in_valid   in   1    in_guess/in_len/in_last valid
//  in_ready   out  1    padder can accept (registered)
//  in_guess   in   128  char0 in [127:120], char1 in [119:112], ...
//  in_len     in   5    message length in bytes, 0..16
//  in_last    in   1    final guess of the keyspace (generator done)
//  out_valid  out  1    out_block valid
//  out_ready  in   1    MD5 core accepts out_block
//  out_block  out  512  word w at [32w+31:32w], w = 0..15
//  out_last   out  1    block derived from an in_last guess
//  len_err    out  1    sticky: an in_len > MAX_CHARS was accepted
//  blk_count  out  CNT_W  emitted blocks (PADDER_COUNT_EN only)
// BEHAVIOUR
//  - Reset: in_ready=1, out_valid=0, out_block=0, out_last=0, len_err=0,
//    blk_count=0; both skid entries emptied. Reset mid-transfer drops data.
//  - Transfers: in_valid&in_ready accepts; out_valid&out_ready consumes.
//    out_valid holds, and out_block/out_last stay stable, until consumed.
//  - Latency: 1 cycle from acceptance to out_valid when the output is empty.
//  - Storage: output register plus one skid register. in_ready = !skid_full.
//    Accept while output is stalled -> entry goes to skid. Output consumed
//    with skid full -> skid moves to output next cycle, in_ready returns 1.
//    Simultaneous accept and consume with skid empty -> new block to output,
//    no bubble. Sustains 1 block/cycle while out_ready=1.
//  - Formatting (L = effective length): byte i = in_guess[127-8i -: 8] for i<L;
//    byte L = 0x80; bytes L+1..55 = 0x00. Word w = {b[4w+3],b[4w+2],b[4w+1],
//    b[4w]} (little-endian). Word14 = L*8 (zero-extended to 32b); word15 = 0.
//    Guess bytes at i>=L are masked to zero regardless of input content.
//  - in_len > MAX_CHARS: L clamped to MAX_CHARS, len_err set; cleared only by
//    reset. L=0 -> word0=0x00000080, all others 0.
//  - out_last mirrors the in_last of the same entry; no other state effect.
// CONFIGURATION
//  PADDER_COUNT_EN defined: blk_count increments by 1 on each out_valid&
//   out_ready, wraps to 0 after 2^CNT_W-1; cleared by reset.
//  PADDER_COUNT_EN undefined: blk_count port absent, no counter logic.
// TESTING
//  - "abc" L=3, out_ready=1 -> next cycle word0=0x80636261, word14=0x18,
//    other words 0, out_last=0.
//  - L=16 "aaaaaaaaaaaaaaaa" -> words0..3=0x61616161, word4=0x00000080,
//    word14=0x80; L=0 -> word0=0x80, word14=0.
//  - in_len=20 -> block as L=16, len_err=1 and stays 1 until reset.
//  - out_ready=0, push 2 guesses -> in_ready=0 after 2nd; 3rd held; release
//    out_ready -> all 3 emitted in order, no loss or duplication.
//  - Continuous in_valid/out_ready=1 for 100 guesses -> 100 blocks, one per
//    cycle; last carries out_last=1 (blk_count=100 with PADDER_COUNT_EN).
//  - Assert reset with both entries full -> next cycle out_valid=0,
//    in_ready=1, len_err=0, blk_count=0.

Source files
------------

// File: rtl/md5_block_padder.sv
// MD5 single-block padder: formats one null-terminated guess into a 512-bit message block
// behind a two-entry (output + skid) registered buffer. Optional counter: PADDER_COUNT_EN.
module md5_block_padder #(
    parameter int MAX_CHARS = 16,
    parameter int CNT_W     = 48
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*MAX_CHARS-1:0] in_guess,
    input  logic [4:0]             in_len,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [511:0]           out_block,
    output logic                   out_last,
`ifdef PADDER_COUNT_EN
    output logic [CNT_W-1:0]       blk_count,
`endif
    output logic                   len_err
);

    localparam logic [4:0] MAX_LEN = 5'(MAX_CHARS);

    // Message bytes (masked beyond len), 0x80 terminator, bit length in word 14.
    function automatic logic [511:0] pad_block(input logic [8*MAX_CHARS-1:0] guess,
                                               input logic [4:0]             len);
        logic [511:0] blk;
        blk = 512'h0;
        for (int i = 0; i < MAX_CHARS; i++) begin
            if (i < int'(len)) begin
                blk[8*i +: 8] = guess[8*(MAX_CHARS-1-i) +: 8];
            end else begin
                blk[8*i +: 8] = 8'h00;
            end
        end
        blk[8*int'(len) +: 8] = 8'h80;
        blk[448 +: 32]        = {24'h000000, len, 3'b000};
        return blk;
    endfunction

    logic         out_valid_q, out_valid_d;
    logic         out_last_q, out_last_d;
    logic [511:0] out_block_q, out_block_d;
    logic         skid_valid_q, skid_valid_d;
    logic         skid_last_q, skid_last_d;
    logic [511:0] skid_block_q, skid_block_d;
    logic         in_ready_q, in_ready_d;
    logic         len_err_q, len_err_d;
    logic         accept_s;
    logic         consume_s;
    logic         len_over_s;
    logic [4:0]   eff_len_s;
    logic [511:0] new_block_s;

    assign accept_s    = in_valid & in_ready_q;
    assign consume_s   = out_valid_q & out_ready;
    assign len_over_s  = (in_len > MAX_LEN);
    assign eff_len_s   = len_over_s ? MAX_LEN : in_len;
    assign new_block_s = pad_block(in_guess, eff_len_s);

    // Next-state for output register, skid register, ready and sticky length error.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_block_d  = out_block_q;
        skid_valid_d = skid_valid_q;
        skid_last_d  = skid_last_q;
        skid_block_d = skid_block_q;
        if (!out_valid_q || out_ready) begin
            // Output slot frees up: the older skid entry always goes first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_last_d   = skid_last_q;
                out_block_d  = skid_block_q;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                out_valid_d = 1'b1;
                out_last_d  = in_last;
                out_block_d = new_block_s;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_valid_d = 1'b1;
                skid_last_d  = in_last;
                skid_block_d = new_block_s;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
        in_ready_d = ~skid_valid_d;
        len_err_d  = len_err_q | (accept_s & len_over_s);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_block_q  <= 512'h0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_block_q <= 512'h0;
            in_ready_q   <= 1'b1;
            len_err_q    <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_block_q  <= out_block_d;
            skid_valid_q <= skid_valid_d;
            skid_last_q  <= skid_last_d;
            skid_block_q <= skid_block_d;
            in_ready_q   <= in_ready_d;
            len_err_q    <= len_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_block = out_block_q;
    assign len_err   = len_err_q;

`ifdef PADDER_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Emitted-block counter, wraps naturally at 2^CNT_W.
    always_comb begin
        if (consume_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign blk_count = cnt_q;
`else
    logic unused_consume_s;
    assign unused_consume_s = consume_s;
`endif

endmodule

// File: tb/tb_md5_block_padder.sv
// Randomized and directed bench for md5_block_padder against a byte-level padding
// model and an occupancy-count buffer model.
module tb_md5_block_padder;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_guess;
    logic [4:0]   in_len;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_block;
    logic         out_last;
    logic         len_err;
`ifdef PADDER_COUNT_EN
    logic [47:0]  blk_count;
`endif

    md5_block_padder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_guess  (in_guess),
        .in_len    (in_len),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .out_last  (out_last),
`ifdef PADDER_COUNT_EN
        .blk_count (blk_count),
`endif
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [511:0] exp_blk_q[$];
    logic         exp_last_q[$];
    logic         exp_err;
    longint       consumed;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference: build the 64-byte MD5 message, then read it as little-endian words.
    function automatic logic [511:0] ref_block(input logic [127:0] g, input int len);
        logic [7:0]   b[64];
        logic [511:0] blk;
        int           l;
        l = (len > 16) ? 16 : len;
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        for (int i = 0; i < l; i++) b[i] = g[127-8*i -: 8];
        b[l]  = 8'h80;
        b[56] = 8'(l * 8);
        for (int w = 0; w < 16; w++)
            blk[32*w +: 32] = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
        return blk;
    endfunction

    // One clock: check outputs against the model, drive inputs, update model.
    task automatic step(input logic v, input logic [127:0] g, input logic [4:0] l,
                        input logic la, input logic rdy);
        @(negedge clk);
        check("in_ready", {511'h0, in_ready}, {511'h0, exp_blk_q.size() < 2});
        check("out_valid", {511'h0, out_valid}, {511'h0, exp_blk_q.size() != 0});
        check("len_err", {511'h0, len_err}, {511'h0, exp_err});
`ifdef PADDER_COUNT_EN
        check("blk_count", {464'h0, blk_count}, {464'h0, consumed[47:0]});
`endif
        if (out_valid && exp_blk_q.size() != 0) begin
            check("out_block", out_block, exp_blk_q[0]);
            check("out_last", {511'h0, out_last}, {511'h0, exp_last_q[0]});
        end
        in_valid  = v;
        in_guess  = g;
        in_len    = l;
        in_last   = la;
        out_ready = rdy;
        if (rdy && out_valid && exp_blk_q.size() != 0) begin
            void'(exp_blk_q.pop_front());
            void'(exp_last_q.pop_front());
            consumed++;
        end
        if (v && in_ready) begin
            exp_blk_q.push_back(ref_block(g, int'(l)));
            exp_last_q.push_back(la);
            if (l > 5'd16) exp_err = 1'b1;
        end
        @(posedge clk);
    endtask

    function automatic logic [127:0] rand_guess();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [511:0] k;
    longint       base;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_guess = 128'h0; in_len = 5'd0;
        in_last = 1'b0; out_ready = 1'b0;
        exp_err = 1'b0; consumed = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {511'h0, in_ready}, {511'h0, 1'b1});
        check("rst_out_valid", {511'h0, out_valid}, 512'h0);
        check("rst_out_block", out_block, 512'h0);
        check("rst_out_last", {511'h0, out_last}, 512'h0);
        check("rst_len_err", {511'h0, len_err}, 512'h0);
        @(negedge clk);
        reset = 1'b0;

        // "abc": one-cycle latency and exact words.
        step(1'b1, {8'h61, 8'h62, 8'h63, 8'hff, 96'hdeadbeef_01234567_89abcdef}, 5'd3, 1'b0, 1'b1);
        #1;
        k = 512'h0; k[31:0] = 32'h80636261; k[14*32 +: 32] = 32'h18;
        check("abc_valid", {511'h0, out_valid}, {511'h0, 1'b1});
        check("abc_block", out_block, k);
        // 16 x 'a'
        step(1'b1, {16{8'h61}}, 5'd16, 1'b0, 1'b1);
        #1;
        k = 512'h0; k[127:0] = {4{32'h61616161}}; k[159:128] = 32'h80; k[14*32 +: 32] = 32'h80;
        check("a16_block", out_block, k);
        // empty guess
        step(1'b1, rand_guess(), 5'd0, 1'b0, 1'b1);
        #1;
        k = 512'h0; k[31:0] = 32'h80;
        check("l0_block", out_block, k);
        // over-length clamps to 16 and latches len_err
        step(1'b1, {16{8'h61}}, 5'd20, 1'b1, 1'b1);
        #1;
        k = 512'h0; k[127:0] = {4{32'h61616161}}; k[159:128] = 32'h80; k[14*32 +: 32] = 32'h80;
        check("clamp_block", out_block, k);
        check("clamp_err", {511'h0, len_err}, {511'h0, 1'b1});
        check("clamp_last", {511'h0, out_last}, {511'h0, 1'b1});
        step(1'b0, 128'h0, 5'd0, 1'b0, 1'b1);
        step(1'b0, 128'h0, 5'd0, 1'b0, 1'b1);

        // Backpressure: two fill output+skid, third is held until room returns.
        step(1'b1, rand_guess(), 5'd4, 1'b0, 1'b0);
        step(1'b1, rand_guess(), 5'd7, 1'b0, 1'b0);
        k[127:0] = rand_guess();
        step(1'b1, k[127:0], 5'd9, 1'b1, 1'b0);
        step(1'b1, k[127:0], 5'd9, 1'b1, 1'b0);
        step(1'b1, k[127:0], 5'd9, 1'b1, 1'b1);
        step(1'b1, k[127:0], 5'd9, 1'b1, 1'b1);
        repeat (4) step(1'b0, 128'h0, 5'd0, 1'b0, 1'b1);
        check("bp_drained", {480'h0, 32'(exp_blk_q.size())}, 512'h0);

        // 100 back-to-back guesses at full rate.
        base = consumed;
        for (int i = 0; i < 100; i++)
            step(1'b1, rand_guess(), 5'($urandom_range(0, 16)), i == 99, 1'b1);
        step(1'b0, 128'h0, 5'd0, 1'b0, 1'b1);
        step(1'b0, 128'h0, 5'd0, 1'b0, 1'b1);
        check("stream_count", {448'h0, 64'(consumed - base)}, {448'h0, 64'd100});

        // Random traffic, lengths beyond the clamp included.
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 3) != 0, rand_guess(), 5'($urandom_range(0, 20)),
                 1'($urandom), $urandom_range(0, 2) != 0);

        // Fill both entries, then reset.
        step(1'b1, rand_guess(), 5'd5, 1'b0, 1'b0);
        step(1'b1, rand_guess(), 5'd21, 1'b0, 1'b0);
        step(1'b1, rand_guess(), 5'd21, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_rst_full", {511'h0, in_ready}, 512'h0);
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst2_out_valid", {511'h0, out_valid}, 512'h0);
        check("rst2_in_ready", {511'h0, in_ready}, {511'h0, 1'b1});
        check("rst2_len_err", {511'h0, len_err}, 512'h0);
`ifdef PADDER_COUNT_EN
        check("rst2_count", {464'h0, blk_count}, 512'h0);
`endif
        exp_blk_q.delete(); exp_last_q.delete(); exp_err = 1'b0; consumed = 0;
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, rand_guess(), 5'd11, 1'b1, 1'b1);
        repeat (3) step(1'b0, 128'h0, 5'd0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
